// File: rtl/add64_seq_arb.sv
// Two-requester round-robin adder: each N-bit sum is produced by one N/2-bit slice
// used twice (low half, then high half), with a registered valid/ready result port.
module add64_seq_arb #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_s,
  output logic         res_cout,
  output logic         res_id
);

  localparam int unsigned H = N / 2;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic           cin_q, cin_d;
  logic           id_q, id_d;
  logic           carry_q, carry_d;
  logic [H-1:0]   s_lo_q, s_lo_d;
  logic [N-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
  logic           rid_q, rid_d;
  logic           rvalid_q, rvalid_d;

  logic           grant0, grant1;
  logic [H-1:0]   sl_a, sl_b;
  logic           sl_c;
  logic [H:0]     sl_sum;

  // The pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~ptr_q);
    grant1 = req1_valid & (~req0_valid | ptr_q);
  end

  assign req0_ready = (state_q == StIdle) & ~rst & grant0;
  assign req1_ready = (state_q == StIdle) & ~rst & grant1;

  // Shared half-width slice: operand halves selected by the current phase.
  always_comb begin
    if (state_q == StHi) begin
      sl_a = a_q[N-1:H];
      sl_b = b_q[N-1:H];
      sl_c = carry_q;
    end else begin
      sl_a = a_q[H-1:0];
      sl_b = b_q[H-1:0];
      sl_c = cin_q;
    end
    sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{H{1'b0}}, sl_c};
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    id_d     = id_q;
    carry_d  = carry_q;
    s_lo_d   = s_lo_q;
    s_d      = s_q;
    cout_d   = cout_q;
    rid_d    = rid_q;
    rvalid_d = rvalid_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          cin_d   = grant1 ? req1_cin : req0_cin;
          id_d    = grant1;
          ptr_d   = grant0;
          state_d = StLo;
        end
      end
      StLo: begin
        s_lo_d  = sl_sum[H-1:0];
        carry_d = sl_sum[H];
        state_d = StHi;
      end
      StHi: begin
        // Result registers update only here so outputs hold between operations.
        s_d      = {sl_sum[H-1:0], s_lo_q};
        cout_d   = sl_sum[H];
        rid_d    = id_q;
        rvalid_d = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      id_q     <= 1'b0;
      carry_q  <= 1'b0;
      s_lo_q   <= '0;
      s_q      <= '0;
      cout_q   <= 1'b0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      id_q     <= id_d;
      carry_q  <= carry_d;
      s_lo_q   <= s_lo_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
      rid_q    <= rid_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign res_valid = rvalid_q;
  assign res_s     = s_q;
  assign res_cout  = cout_q;
  assign res_id    = rid_q;

endmodule

// File: doc/add64_seq_arb.md
ADD64_SEQ_ARB -- requirements
Module: add64_seq_arb

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning operand/result width in bits; it SHALL be even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has an operation pending.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 The block SHALL have ports req0_a and req0_b, input, N bits each, and req0_cin, input, 1 bit: requester 0 operands and carry-in.
REQ-007 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_cin, with the same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-008 The block SHALL have port res_valid, output, 1 bit: a result is presented.
REQ-009 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port res_s, output, N bits: the sum.
REQ-011 The block SHALL have port res_cout, output, 1 bit: the carry-out.
REQ-012 The block SHALL have port res_id, output, 1 bit: the index of the requester that owns the result.

Function
REQ-013 The block SHALL compute every sum with one shared N/2-bit add slice used twice per operation, low half then high half; a full N-bit adder SHALL NOT be used.
REQ-014 The FSM SHALL have exactly four states: IDLE, LO, HI and DONE.
REQ-015 IDLE behaviour:
- reqX_ready SHALL be high only for the granted requester, and only in IDLE.
- The grant SHALL be decided combinationally from the valid inputs and the priority pointer.
REQ-016 IDLE transition and capture: on a handshake the FSM SHALL go to LO and latch a, b, cin and the owner id; with no valid request it SHALL stay in IDLE.
REQ-017 LO: slice computes a[N/2-1:0]+b[N/2-1:0]+cin; s[N/2-1:0] and the internal carry SHALL be registered; next state SHALL be HI.
REQ-018 HI: slice computes a[N-1:N/2]+b[N-1:N/2]+carry; s[N-1:N/2] and res_cout SHALL be registered; next state SHALL be DONE.
REQ-019 DONE: res_valid SHALL be 1, with res_s, res_cout and res_id stable.
REQ-020 DONE exit: on res_ready=1 the FSM SHALL go to IDLE; otherwise it SHALL hold in DONE for any number of cycles.
REQ-021 Latency: a handshake in cycle T SHALL give res_valid=1 in cycle T+3 at the earliest.
REQ-022 Throughput: with res_ready tied high, the block SHALL accept one operation every 4 cycles.
REQ-023 Arbitration: round-robin with a 1-bit priority pointer.
- If only one requester is valid, it SHALL be granted.
- If both are valid, the requester named by the pointer SHALL be granted.
- After every grant, the pointer SHALL move to the other requester.
REQ-024 A request left ungranted SHALL keep its valid high and operands stable until granted; the block SHALL NOT drop or reorder accepted work.
REQ-025 Arithmetic SHALL be modulo 2^N, with res_cout equal to bit N of a+b+cin, including the all-ones + all-ones + 1 case.
REQ-026 Outputs SHALL be registered; outside DONE, res_s, res_cout and res_id SHALL hold their last values and res_valid SHALL be 0.
REQ-027 Latched operands SHALL NOT be affected by input changes after the handshake.

Reset
REQ-028 On rst=1 at a clock edge, the FSM SHALL go to IDLE, res_valid, res_s, res_cout and res_id SHALL become 0, and the pointer SHALL become 0 (requester 0 first).
REQ-029 rst SHALL take priority over every other input in any state; an operation in flight SHALL be discarded without producing res_valid.
REQ-030 While rst=1, req0_ready and req1_ready SHALL be 0.

Verification
REQ-031 N=64, req0 a=0xFFFFFFFF, b=1, cin=0, res_ready=1 -> res_s=0x0000000100000000, res_cout=0, res_id=0, res_valid 3 cycles after the handshake.
REQ-032 a=b=0xFFFFFFFFFFFFFFFF, cin=1 -> res_s=0xFFFFFFFFFFFFFFFF, res_cout=1.
REQ-033 Both requesters valid continuously after reset, res_ready=1 -> grants alternate 0,1,0,1; each res_id matches its own operands' sum.
REQ-034 res_ready held 0 for 5 cycles in DONE -> res_valid stays 1, outputs stable, no reqX_ready asserted; accept on cycle 6 -> IDLE next cycle.
REQ-035 rst asserted for one cycle while in HI -> next cycle IDLE, res_valid=0, res_s=0, and the next operation is granted to req0 when both requesters are valid.
REQ-036 req1_a changed in the cycle after its handshake -> result reflects the originally latched operands.
